// File: rtl/fifo_reader.sv
// Drains a word-oriented fifo in bursts and presents each word on a valid/ready port.
// A burst starts on a full fifo (or on request) and ends on the last word, on FIFO_SIZE words, or when enable drops.
module fifo_reader #(
  parameter int FIFO_SIZE  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_ready,
  input  logic                  pushed_last,
  input  logic                  popped_last,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  pop_clock,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  burst_done,
  output logic                  burst_aborted,
  output logic [15:0]           burst_count,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [15:0] LAST_INDEX = 16'(FIFO_SIZE - 1);

  state_t      state;
  logic [15:0] word_count;
  logic        last_word;
  logic        armed;
  logic        start_ok;

  // armed keeps the first edge after clear release from starting a burst.
  assign start_ok  = armed && enable && fifo_ready && (pushed_last || flush);
  assign fsm_state = state;

  // Handshake: a word transfers on a rising edge where out_valid and out_ready are both 1;
  // while out_valid=1 and out_ready=0, out_data and out_last hold and no pop is issued.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state         <= IDLE;
      word_count    <= 16'd0;
      last_word     <= 1'b0;
      armed         <= 1'b0;
      pop_clock     <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      burst_done    <= 1'b0;
      burst_aborted <= 1'b0;
      burst_count   <= 16'd0;
    end else begin
      armed         <= 1'b1;
      pop_clock     <= 1'b0;
      burst_done    <= 1'b0;
      burst_aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= POP;
            pop_clock  <= 1'b1;
            word_count <= 16'd0;
          end
        end
        POP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= fifo_data;
          last_word <= popped_last || (word_count == LAST_INDEX);
          out_last  <= popped_last || (word_count == LAST_INDEX);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid) begin
            if (out_ready) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              word_count <= word_count + 16'd1;
              if (last_word) begin
                state       <= IDLE;
                burst_done  <= 1'b1;
                burst_count <= burst_count + 16'd1;
              end else if (!enable) begin
                state         <= IDLE;
                burst_aborted <= 1'b1;
              end else if (fifo_ready) begin
                state     <= POP;
                pop_clock <= 1'b1;
              end
            end
          end else if (fifo_ready) begin
            // Non-valid wait after an accepted word: the continue decision is already made.
            state     <= POP;
            pop_clock <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter FIFO_SIZE, default 8, words per full burst; SHALL match the attached fifo instance.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 Port clock, input, 1: single clock; all logic SHALL be rising-edge sequential on it.
REQ-004 Port clear, input, 1: reset, asynchronous, active-high.
REQ-005 Port enable, input, 1: allows burst start and continuation.
REQ-006 Port flush, input, 1: requests a burst on a non-full fifo.
REQ-007 Port fifo_ready, input, 1: fifo not busy.
REQ-008 Port pushed_last, input, 1: fifo full flag.
REQ-009 Port popped_last, input, 1: fifo emptied by latest pop.
REQ-010 Port fifo_data, input, DATA_WIDTH: fifo output word.
REQ-011 Port pop_clock, output, 1: pop strobe to fifo, registered.
REQ-012 Port out_data, output, DATA_WIDTH: downstream word.
REQ-013 Port out_valid, output, 1: out_data valid.
REQ-014 Port out_ready, input, 1: downstream accepts.
REQ-015 Port out_last, output, 1: final word of burst, qualified by out_valid.
REQ-016 Port burst_done, output, 1: one-cycle pulse on completed burst.
REQ-017 Port burst_aborted, output, 1: one-cycle pulse on enable-terminated burst.
REQ-018 Port burst_count, output, 16: completed bursts, wraps 0xFFFF->0.

Function
REQ-019 FSM states IDLE, POP, CAPTURE, HOLD; one state per cycle except HOLD.
REQ-020 IDLE->POP when enable=1, fifo_ready=1, and (pushed_last=1 or flush=1); word_count cleared to 0.
REQ-021 POP: pop_clock=1 for exactly this cycle; next state CAPTURE unconditionally.
REQ-022 CAPTURE: pop_clock=0; at cycle end latch fifo_data into out_data, set last_word = popped_last or (word_count==FIFO_SIZE-1); next HOLD.
REQ-023 HOLD: out_valid=1, out_last=last_word; out_data and out_last stable until out_ready=1.
REQ-024 HOLD with out_ready=1: word_count+1; if last_word -> IDLE, burst_done pulse next cycle, burst_count+1.
REQ-025 HOLD with out_ready=1, not last_word: enable=1 and fifo_ready=1 -> POP; enable=0 -> IDLE with burst_aborted pulse; fifo_ready=0 -> wait in a non-valid sub-cycle (out_valid=0) until fifo_ready=1.
REQ-026 Minimum cost 3 cycles per word with out_ready held high; no pop SHALL issue while out_valid=1 and unaccepted.
REQ-027 Never more than FIFO_SIZE pops per burst; never a pop after popped_last sampled 1.
REQ-028 flush and pushed_last both 1 in IDLE: single burst, identical behaviour.
REQ-029 word_count 16 bits, compare against FIFO_SIZE-1 unsigned.
REQ-030 enable and flush ignored outside IDLE and the HOLD exit decision.

Reset
REQ-031 clear=1 SHALL immediately force IDLE; pop_clock, out_valid, out_last, burst_done, burst_aborted =0; out_data=0; word_count=0; burst_count=0.
REQ-032 clear asserted mid-burst SHALL drop the in-flight word with no pulse; first pop after release no earlier than second rising edge.

Verification
REQ-033 Fill fifo with 1..8, enable=1, out_ready=1 -> 8 pop pulses 3 cycles apart, out_data 1..8, out_last only on 8, burst_done once, burst_count=1.
REQ-034 3 words 0xA,0xB,0xC, flush pulse -> 3 words output, out_last on 0xC (popped_last), no 4th pop.
REQ-035 Full burst, out_ready low 5 cycles on word 2 -> out_valid and data 2 held 5 cycles, no pop_clock during stall.
REQ-036 enable dropped during word 4 HOLD, then out_ready -> word 4 accepted, burst_aborted pulse, return IDLE, 4 pops total.
REQ-037 clear asserted in CAPTURE -> all outputs 0 same cycle, burst_count=0, no burst_done.
REQ-038 burst_count preset via 65535 bursts, one more -> burst_count=0.
